// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_ex_operand_stage: ID/EX register with EX/MEM and MEM/WB forwarding      |
// | feeding the ALU operands; supports stall (hold) and flush (bubble).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic              id_alu_src_imm,
  input  logic              id_use_shamt,
  input  logic              id_reg_write,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] ex_in1,
  output logic [DATA_W-1:0] ex_in2,
  output logic [OP_W-1:0]   ex_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_valid
);

  localparam logic [OP_W-1:0]   c_alu_add = '0;
  localparam logic [REG_AW-1:0] c_reg_zero = '0;

  logic              valid_q,       valid_d;
  logic [REG_AW-1:0] rs_addr_q,     rs_addr_d;
  logic [REG_AW-1:0] rt_addr_q,     rt_addr_d;
  logic [REG_AW-1:0] rd_addr_q,     rd_addr_d;
  logic [DATA_W-1:0] rs_data_q,     rs_data_d;
  logic [DATA_W-1:0] rt_data_q,     rt_data_d;
  logic [DATA_W-1:0] imm_q,         imm_d;
  logic [4:0]        shamt_q,       shamt_d;
  logic [OP_W-1:0]   alu_op_q,      alu_op_d;
  logic              alu_src_imm_q, alu_src_imm_d;
  logic              use_shamt_q,   use_shamt_d;
  logic              reg_write_q,   reg_write_d;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  always_comb begin
    valid_d       = valid_q;
    rs_addr_d     = rs_addr_q;
    rt_addr_d     = rt_addr_q;
    rd_addr_d     = rd_addr_q;
    rs_data_d     = rs_data_q;
    rt_data_d     = rt_data_q;
    imm_d         = imm_q;
    shamt_d       = shamt_q;
    alu_op_d      = alu_op_q;
    alu_src_imm_d = alu_src_imm_q;
    use_shamt_d   = use_shamt_q;
    reg_write_d   = reg_write_q;

    if (flush) begin
      valid_d       = 1'b0;
      rs_addr_d     = '0;
      rt_addr_d     = '0;
      rd_addr_d     = '0;
      rs_data_d     = '0;
      rt_data_d     = '0;
      imm_d         = '0;
      shamt_d       = '0;
      alu_op_d      = c_alu_add;
      alu_src_imm_d = 1'b0;
      use_shamt_d   = 1'b0;
      reg_write_d   = 1'b0;
    end else if (stall) begin
      // A write-back retiring while we are held would otherwise be missed,
      // since it leaves the forwarding window before the stall releases.
      if (wb_reg_write && (wb_rd != c_reg_zero) && (wb_rd == rs_addr_q))
        rs_data_d = wb_data;
      if (wb_reg_write && (wb_rd != c_reg_zero) && (wb_rd == rt_addr_q))
        rt_data_d = wb_data;
    end else begin
      valid_d       = id_valid;
      rs_addr_d     = id_rs_addr;
      rt_addr_d     = id_rt_addr;
      rd_addr_d     = id_rd_addr;
      rs_data_d     = id_rs_data;
      rt_data_d     = id_rt_data;
      imm_d         = id_imm;
      shamt_d       = id_shamt;
      alu_op_d      = id_alu_op;
      alu_src_imm_d = id_alu_src_imm;
      use_shamt_d   = id_use_shamt;
      reg_write_d   = id_reg_write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= 1'b0;
      rs_addr_q     <= '0;
      rt_addr_q     <= '0;
      rd_addr_q     <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      shamt_q       <= '0;
      alu_op_q      <= c_alu_add;
      alu_src_imm_q <= 1'b0;
      use_shamt_q   <= 1'b0;
      reg_write_q   <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      rs_addr_q     <= rs_addr_d;
      rt_addr_q     <= rt_addr_d;
      rd_addr_q     <= rd_addr_d;
      rs_data_q     <= rs_data_d;
      rt_data_q     <= rt_data_d;
      imm_q         <= imm_d;
      shamt_q       <= shamt_d;
      alu_op_q      <= alu_op_d;
      alu_src_imm_q <= alu_src_imm_d;
      use_shamt_q   <= use_shamt_d;
      reg_write_q   <= reg_write_d;
    end
  end

  // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
  always_comb begin
    fwd_rs = rs_data_q;
    if (mem_reg_write && (mem_rd == rs_addr_q) && (rs_addr_q != c_reg_zero))
      fwd_rs = mem_result;
    else if (wb_reg_write && (wb_rd == rs_addr_q) && (rs_addr_q != c_reg_zero))
      fwd_rs = wb_data;
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (mem_reg_write && (mem_rd == rt_addr_q) && (rt_addr_q != c_reg_zero))
      fwd_rt = mem_result;
    else if (wb_reg_write && (wb_rd == rt_addr_q) && (rt_addr_q != c_reg_zero))
      fwd_rt = wb_data;
  end

  assign ex_in1        = use_shamt_q ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_rs;
  assign ex_in2        = alu_src_imm_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_op         = alu_op_q;
  assign ex_rd         = rd_addr_q;
  assign ex_reg_write  = reg_write_q & valid_q;
  assign ex_valid      = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_id_ex_operand_stage: directed self-checking bench for the ID/EX stage.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_id_ex_operand_stage;

  localparam logic [3:0] c_op_add  = 4'h0;
  localparam logic [3:0] c_op_sub  = 4'h2;
  localparam logic [3:0] c_op_sll  = 4'h3;
  localparam logic [3:0] c_op_sllv = 4'h6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall, flush, id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]  id_alu_op;
  logic        id_alu_src_imm, id_use_shamt, id_reg_write;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_data;
  logic [31:0] ex_in1, ex_in2, ex_store_data;
  logic [3:0]  ex_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_valid;

  int checks = 0;
  int failures = 0;

  id_ex_operand_stage #(.DATA_W(32), .REG_AW(5), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_alu_src_imm(id_alu_src_imm),
    .id_use_shamt(id_use_shamt), .id_reg_write(id_reg_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_op(ex_op), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_valid(ex_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; id_valid = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_shamt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alu_op = c_op_add;
    id_alu_src_imm = 0; id_use_shamt = 0; id_reg_write = 0;
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic load_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rs_d, input logic [31:0] rt_d,
                            input logic [3:0] op, input logic rw);
    id_valid = 1; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rs_d; id_rt_data = rt_d; id_alu_op = op; id_reg_write = rw;
    id_alu_src_imm = 0; id_use_shamt = 0; id_imm = 0; id_shamt = 0;
  endtask

  task automatic test_reset();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL rst_init_valid got=%0b exp=0", ex_valid); end
    rst = 0;
    step();
    load_instr(5'd1, 5'd2, 5'd4, 32'h5, 32'h7, c_op_sub, 1'b1);
    step();
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL rst_preload_valid got=%0b exp=1", ex_valid); end
    stall = 1; flush = 1;
    #2 rst = 1;
    #1;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%0b exp=0", ex_valid); end
    checks++; if (ex_reg_write !== 1'b0) begin failures++; $display("FAIL rst_async_rw got=%0b exp=0", ex_reg_write); end
    checks++; if (ex_rd !== 5'd0) begin failures++; $display("FAIL rst_async_rd got=%0d exp=0", ex_rd); end
    checks++; if (ex_op !== c_op_add) begin failures++; $display("FAIL rst_async_op got=%0h exp=%0h", ex_op, c_op_add); end
    checks++; if (ex_in1 !== 32'h0) begin failures++; $display("FAIL rst_async_in1 got=%0h exp=0", ex_in1); end
    checks++; if (ex_in2 !== 32'h0) begin failures++; $display("FAIL rst_async_in2 got=%0h exp=0", ex_in2); end
    checks++; if (ex_store_data !== 32'h0) begin failures++; $display("FAIL rst_async_st got=%0h exp=0", ex_store_data); end
    step();
    idle_inputs();
    rst = 0;
    step();
  endtask

  task automatic test_pass_through();
    load_instr(5'd1, 5'd2, 5'd4, 32'h5, 32'h7, c_op_add, 1'b1);
    step();
    checks++; if (ex_in1 !== 32'h5) begin failures++; $display("FAIL pass_in1 got=%0h exp=5", ex_in1); end
    checks++; if (ex_in2 !== 32'h7) begin failures++; $display("FAIL pass_in2 got=%0h exp=7", ex_in2); end
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL pass_valid got=%0b exp=1", ex_valid); end
    checks++; if (ex_reg_write !== 1'b1) begin failures++; $display("FAIL pass_rw got=%0b exp=1", ex_reg_write); end
    checks++; if (ex_rd !== 5'd4) begin failures++; $display("FAIL pass_rd got=%0d exp=4", ex_rd); end
    checks++; if (ex_store_data !== 32'h7) begin failures++; $display("FAIL pass_st got=%0h exp=7", ex_store_data); end
    // Immediate operand replaces rt on In2 but store data still carries rt.
    load_instr(5'd1, 5'd2, 5'd5, 32'h5, 32'h55, c_op_add, 1'b1);
    id_alu_src_imm = 1; id_imm = 32'h100;
    step();
    checks++; if (ex_in2 !== 32'h100) begin failures++; $display("FAIL imm_in2 got=%0h exp=100", ex_in2); end
    checks++; if (ex_store_data !== 32'h55) begin failures++; $display("FAIL imm_st got=%0h exp=55", ex_store_data); end
    // Valid low masks the write enable.
    load_instr(5'd1, 5'd2, 5'd5, 32'h5, 32'h55, c_op_add, 1'b1);
    id_valid = 0;
    step();
    checks++; if (ex_reg_write !== 1'b0) begin failures++; $display("FAIL inval_rw got=%0b exp=0", ex_reg_write); end
  endtask

  task automatic test_priority();
    load_instr(5'd3, 5'd8, 5'd9, 32'h11, 32'h22, c_op_add, 1'b1);
    step();
    mem_reg_write = 1; mem_rd = 5'd3; mem_result = 32'hAA;
    wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'hBB;
    #1;
    checks++; if (ex_in1 !== 32'hAA) begin failures++; $display("FAIL prio_mem got=%0h exp=aa", ex_in1); end
    mem_reg_write = 0;
    #1;
    checks++; if (ex_in1 !== 32'hBB) begin failures++; $display("FAIL prio_wb got=%0h exp=bb", ex_in1); end
    wb_rd = 5'd8;
    #1;
    checks++; if (ex_in1 !== 32'h11) begin failures++; $display("FAIL prio_none got=%0h exp=11", ex_in1); end
    checks++; if (ex_in2 !== 32'hBB) begin failures++; $display("FAIL prio_rt_wb got=%0h exp=bb", ex_in2); end
    checks++; if (ex_store_data !== 32'hBB) begin failures++; $display("FAIL prio_st_wb got=%0h exp=bb", ex_store_data); end
    wb_reg_write = 0;
  endtask

  task automatic test_reg0();
    load_instr(5'd0, 5'd0, 5'd1, 32'h0, 32'h0, c_op_add, 1'b1);
    step();
    mem_reg_write = 1; mem_rd = 5'd0; mem_result = 32'hFF;
    wb_reg_write = 1; wb_rd = 5'd0; wb_data = 32'hEE;
    #1;
    checks++; if (ex_in1 !== 32'h0) begin failures++; $display("FAIL reg0_in1 got=%0h exp=0", ex_in1); end
    checks++; if (ex_in2 !== 32'h0) begin failures++; $display("FAIL reg0_in2 got=%0h exp=0", ex_in2); end
    mem_reg_write = 0; wb_reg_write = 0;
  endtask

  task automatic test_shifts();
    load_instr(5'd0, 5'd2, 5'd3, 32'h9, 32'h1, c_op_sll, 1'b1);
    id_use_shamt = 1; id_shamt = 5'd4;
    step();
    checks++; if (ex_in1 !== 32'h4) begin failures++; $display("FAIL sll_in1 got=%0h exp=4", ex_in1); end
    checks++; if (ex_in2 !== 32'h1) begin failures++; $display("FAIL sll_in2 got=%0h exp=1", ex_in2); end
    checks++; if (ex_op !== c_op_sll) begin failures++; $display("FAIL sll_op got=%0h exp=%0h", ex_op, c_op_sll); end
    load_instr(5'd5, 5'd2, 5'd3, 32'h77, 32'h1, c_op_sllv, 1'b1);
    id_shamt = 5'd31;
    step();
    mem_reg_write = 1; mem_rd = 5'd5; mem_result = 32'h3;
    #1;
    checks++; if (ex_in1 !== 32'h3) begin failures++; $display("FAIL sllv_in1 got=%0h exp=3", ex_in1); end
    mem_reg_write = 0;
  endtask

  task automatic test_stall_flush();
    load_instr(5'd7, 5'd6, 5'd9, 32'h20, 32'h10, c_op_sub, 1'b1);
    step();
    stall = 1;
    load_instr(5'd1, 5'd1, 5'd1, 32'hDEAD, 32'hBEEF, c_op_sll, 1'b0);
    wb_reg_write = 1; wb_rd = 5'd6; wb_data = 32'h1234;
    step();
    wb_reg_write = 0; wb_data = 32'h0;
    step();
    step();
    checks++; if (ex_in2 !== 32'h1234) begin failures++; $display("FAIL stall_in2 got=%0h exp=1234", ex_in2); end
    checks++; if (ex_in1 !== 32'h20) begin failures++; $display("FAIL stall_in1 got=%0h exp=20", ex_in1); end
    checks++; if (ex_op !== c_op_sub) begin failures++; $display("FAIL stall_op got=%0h exp=%0h", ex_op, c_op_sub); end
    checks++; if (ex_rd !== 5'd9) begin failures++; $display("FAIL stall_rd got=%0d exp=9", ex_rd); end
    stall = 0;
    step();
    checks++; if (ex_in1 !== 32'hDEAD) begin failures++; $display("FAIL release_in1 got=%0h exp=dead", ex_in1); end
    load_instr(5'd1, 5'd2, 5'd3, 32'h5, 32'h6, c_op_sub, 1'b1);
    stall = 1; flush = 1;
    step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", ex_valid); end
    checks++; if (ex_reg_write !== 1'b0) begin failures++; $display("FAIL flush_rw got=%0b exp=0", ex_reg_write); end
    checks++; if (ex_op !== c_op_add) begin failures++; $display("FAIL flush_op got=%0h exp=0", ex_op); end
    checks++; if (ex_in1 !== 32'h0) begin failures++; $display("FAIL flush_in1 got=%0h exp=0", ex_in1); end
    stall = 0; flush = 0;
  endtask

  task automatic test_back_to_back();
    load_instr(5'd10, 5'd11, 5'd12, 32'h100, 32'h200, c_op_add, 1'b1);
    step();
    load_instr(5'd13, 5'd14, 5'd15, 32'h300, 32'h400, c_op_sub, 1'b1);
    checks++; if (ex_in1 !== 32'h100) begin failures++; $display("FAIL b2b_a_in1 got=%0h exp=100", ex_in1); end
    checks++; if (ex_rd !== 5'd12) begin failures++; $display("FAIL b2b_a_rd got=%0d exp=12", ex_rd); end
    step();
    checks++; if (ex_in2 !== 32'h400) begin failures++; $display("FAIL b2b_b_in2 got=%0h exp=400", ex_in2); end
    checks++; if (ex_op !== c_op_sub) begin failures++; $display("FAIL b2b_b_op got=%0h exp=%0h", ex_op, c_op_sub); end
  endtask

  initial begin
    idle_inputs();
    #7;
    test_reset();
    test_pass_through();
    test_priority();
    test_reg0();
    test_shifts();
    test_stall_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
